lcd_bus_arbiter: RTL and testbench

- Owns the shared character-LCD write bus (RW/RS/DATA) and grants it to exactly one mode display module, chosen by the one-hot MODE vector.
- Runs the LCD power-on init sequence after reset.
- Issues a Clear Display command with a settle gap on every mode change, then passes the selected requester's words through registered, with an enable strobe.
- Sits between the mode display modules (clock, alarm, stopwatch, ...) and the LCD pins.

---
 rtl/lcd_pkg.sv | 54 +++++
 rtl/lcd_bus_arbiter_onehot.sv | 22 ++
 rtl/lcd_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD bus definitions: command bytes, arbiter state encoding and the
// registered output word, plus helpers that build NOP/command words.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET   = 8'h38;
    localparam logic [7:0] DISP_ON    = 8'h0C;
    localparam logic [7:0] ENTRY_MODE = 8'h06;
    localparam logic [7:0] CLEAR      = 8'h01;
    localparam logic [7:0] IDLE_WORD  = 8'h02;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_CLEAR,
        ST_RUN,
        ST_IDLE
    } state_t;

    typedef struct packed {
        logic       rw;
        logic       rs;
        logic [7:0] data;
        logic       e;
    } lcd_word_t;

    function automatic lcd_word_t lcd_nop(input logic [7:0] idle);
        lcd_word_t w;
        w.rw   = 1'b1;
        w.rs   = 1'b1;
        w.data = idle;
        w.e    = 1'b0;
        return w;
    endfunction

    function automatic lcd_word_t lcd_cmd(input logic [7:0] c);
        lcd_word_t w;
        w.rw   = 1'b0;
        w.rs   = 1'b0;
        w.data = c;
        w.e    = 1'b1;
        return w;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] step);
        logic [7:0] c;
        case (step)
            2'd0:    c = FUNC_SET;
            2'd1:    c = DISP_ON;
            2'd2:    c = ENTRY_MODE;
            default: c = CLEAR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_onehot.sv
// One-hot select decoder: index of the set bit plus a flag that exactly one
// bit is set. Index is meaningless when valid is low.
module onehot_to_index #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // clearing the lowest set bit leaves zero only for a single-bit value
    assign valid = (sel != '0) && ((sel & (sel - N'(1))) == '0);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) idx = idx | IDX_W'(i);
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Character-LCD write-bus owner: power-on init, clear on every mode change,
// then registered pass-through of the requester selected by one-hot MODE.
module lcd_bus_arbiter #(
    parameter int         N_REQ      = 4,
    parameter int         CLEAR_WAIT = 2,
    parameter logic [7:0] IDLE_WORD  = lcd_pkg::IDLE_WORD
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [N_REQ-1:0]           MODE,
    input  logic [N_REQ-1:0]           REQ_RW,
    input  logic [N_REQ-1:0]           REQ_RS,
    input  logic [8*N_REQ-1:0]         REQ_DATA,
    output logic                       LCD_RW,
    output logic                       LCD_RS,
    output logic [7:0]                 LCD_DATA,
    output logic                       LCD_E,
    output logic                       BUSY,
    output logic [$clog2(N_REQ)-1:0]   GRANT
);
    import lcd_pkg::*;

    localparam int         IDX_W     = $clog2(N_REQ);
    localparam logic [3:0] WAIT_LAST = 4'(CLEAR_WAIT);

    state_t                     state, state_nx;
    logic [1:0]                 step, step_nx;
    logic [3:0]                 wcnt, wcnt_nx;
    logic [N_REQ-1:0]           cur_mode, cur_mode_nx;
    lcd_word_t                  word_nx;
    logic                       busy_nx;
    logic [IDX_W-1:0]           grant_nx;
    logic [IDX_W-1:0]           mode_idx;
    logic                       mode_ok;
    logic [N_REQ-1:0][7:0]      req_data;

    assign req_data = REQ_DATA;

    // Wherever the index is consumed, MODE equals cur_mode, so one decoder suffices.
    onehot_to_index #(.N(N_REQ), .IDX_W(IDX_W)) u_mode_dec (
        .sel   (MODE),
        .idx   (mode_idx),
        .valid (mode_ok)
    );

    always_comb begin
        state_nx    = state;
        step_nx     = step;
        wcnt_nx     = wcnt;
        cur_mode_nx = cur_mode;
        word_nx     = lcd_nop(IDLE_WORD);
        busy_nx     = 1'b0;
        grant_nx    = '0;
        case (state)
            ST_INIT: begin
                busy_nx = 1'b1;
                // wcnt==0 is the command phase, nonzero counts the settle NOPs
                if (wcnt == 4'd0) begin
                    word_nx = lcd_cmd(init_cmd(step));
                    if (step == 2'd3) wcnt_nx = 4'd1;
                    else              step_nx = step + 2'd1;
                end else if (wcnt != WAIT_LAST) begin
                    wcnt_nx = wcnt + 4'd1;
                end else begin
                    wcnt_nx     = 4'd0;
                    cur_mode_nx = MODE;
                    state_nx    = mode_ok ? ST_RUN : ST_IDLE;
                end
            end
            ST_CLEAR: begin
                busy_nx = 1'b1;
                if (MODE != cur_mode) begin
                    word_nx     = lcd_cmd(CLEAR);
                    cur_mode_nx = MODE;
                    wcnt_nx     = 4'd1;
                end else if (wcnt != WAIT_LAST) begin
                    wcnt_nx = wcnt + 4'd1;
                end else begin
                    wcnt_nx  = 4'd0;
                    state_nx = mode_ok ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (MODE != cur_mode) begin
                    word_nx     = lcd_cmd(CLEAR);
                    busy_nx     = 1'b1;
                    cur_mode_nx = MODE;
                    wcnt_nx     = 4'd1;
                    state_nx    = ST_CLEAR;
                end else begin
                    word_nx.rw   = REQ_RW[mode_idx];
                    word_nx.rs   = REQ_RS[mode_idx];
                    word_nx.data = req_data[mode_idx];
                    word_nx.e    = ~REQ_RW[mode_idx];
                    grant_nx     = mode_idx;
                end
            end
            ST_IDLE: begin
                // invalid-to-invalid changes just track MODE without a clear
                cur_mode_nx = MODE;
                if (mode_ok) begin
                    word_nx  = lcd_cmd(CLEAR);
                    busy_nx  = 1'b1;
                    wcnt_nx  = 4'd1;
                    state_nx = ST_CLEAR;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_INIT;
            step     <= 2'd0;
            wcnt     <= 4'd0;
            cur_mode <= '0;
            LCD_RW   <= 1'b1;
            LCD_RS   <= 1'b1;
            LCD_DATA <= IDLE_WORD;
            LCD_E    <= 1'b0;
            BUSY     <= 1'b1;
            GRANT    <= '0;
        end else begin
            state    <= state_nx;
            step     <= step_nx;
            wcnt     <= wcnt_nx;
            cur_mode <= cur_mode_nx;
            LCD_RW   <= word_nx.rw;
            LCD_RS   <= word_nx.rs;
            LCD_DATA <= word_nx.data;
            LCD_E    <= word_nx.e;
            BUSY     <= busy_nx;
            GRANT    <= grant_nx;
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter: init sequence, pass-through latency,
// mode-change clears, invalid modes, clear restart and asynchronous reset.
module tb_lcd_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] MODE;
    logic [3:0] REQ_RW;
    logic [3:0] REQ_RS;
    logic [31:0] REQ_DATA;
    logic       LCD_RW, LCD_RS, LCD_E, BUSY;
    logic [7:0] LCD_DATA;
    logic [1:0] GRANT;

    int vecs = 0;
    int errs = 0;

    always #5 CLK = ~CLK;

    lcd_bus_arbiter #(.N_REQ(4), .CLEAR_WAIT(2), .IDLE_WORD(8'h02)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MODE     (MODE),
        .REQ_RW   (REQ_RW),
        .REQ_RS   (REQ_RS),
        .REQ_DATA (REQ_DATA),
        .LCD_RW   (LCD_RW),
        .LCD_RS   (LCD_RS),
        .LCD_DATA (LCD_DATA),
        .LCD_E    (LCD_E),
        .BUSY     (BUSY),
        .GRANT    (GRANT)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic rw, input logic rs,
                           input logic [7:0] data, input logic e,
                           input logic busy, input logic [1:0] grant);
        chk($sformatf("%s.rw", tag),    32'(LCD_RW),   32'(rw));
        chk($sformatf("%s.rs", tag),    32'(LCD_RS),   32'(rs));
        chk($sformatf("%s.data", tag),  32'(LCD_DATA), 32'(data));
        chk($sformatf("%s.e", tag),     32'(LCD_E),    32'(e));
        chk($sformatf("%s.busy", tag),  32'(BUSY),     32'(busy));
        chk($sformatf("%s.grant", tag), 32'(GRANT),    32'(grant));
    endtask

    task automatic nop(input string tag, input logic busy);
        chk_out(tag, 1'b1, 1'b1, 8'h02, 1'b0, busy, 2'd0);
    endtask

    task automatic cmd(input string tag, input logic [7:0] c);
        chk_out(tag, 1'b0, 1'b0, c, 1'b1, 1'b1, 2'd0);
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic init_seq(input string tag);
        tick(); cmd({tag, ".c1"}, 8'h38);
        tick(); cmd({tag, ".c2"}, 8'h0C);
        tick(); cmd({tag, ".c3"}, 8'h06);
        tick(); cmd({tag, ".c4"}, 8'h01);
        tick(); nop({tag, ".n1"}, 1'b1);
        tick(); nop({tag, ".n2"}, 1'b1);
    endtask

    // Clear command then the two settle NOPs
    task automatic clear_seq(input string tag);
        tick(); cmd({tag, ".cmd"}, 8'h01);
        tick(); nop({tag, ".n1"}, 1'b1);
        tick(); nop({tag, ".n2"}, 1'b1);
    endtask

    initial begin
        // req3: write RS=1 0x53; req2: read RS=0 0x22; req1: read 0x11; req0: write RS=1 0x30
        RESET    = 1'b0;
        MODE     = 4'b1000;
        REQ_RW   = 4'b0110;
        REQ_RS   = 4'b1001;
        REQ_DATA = {8'h53, 8'h22, 8'h11, 8'h30};
        #12;
        nop("reset", 1'b1);
        RESET = 1'b1;

        init_seq("init");
        tick(); chk_out("run3", 1'b0, 1'b1, 8'h53, 1'b1, 1'b0, 2'd3);

        REQ_DATA[31:24] = 8'h54;
        chk_out("lat.hold", 1'b0, 1'b1, 8'h53, 1'b1, 1'b0, 2'd3);
        tick(); chk_out("lat.new", 1'b0, 1'b1, 8'h54, 1'b1, 1'b0, 2'd3);

        MODE = 4'b0001;
        clear_seq("m0");
        tick(); chk_out("run0", 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 2'd0);

        // RUN into an invalid mode: clear, then idle NOPs with BUSY low
        MODE = 4'b1010;
        clear_seq("inv");
        tick(); nop("idle.a", 1'b0);
        tick(); nop("idle.b", 1'b0);
        MODE = 4'b0110;
        tick(); nop("idle.inv2inv", 1'b0);
        MODE = 4'b0100;
        clear_seq("m2");
        tick(); chk_out("run2", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'd2);

        // MODE change on the first settle NOP restarts the clear
        MODE = 4'b1000;
        tick(); cmd("rst.cmd", 8'h01);
        tick(); nop("rst.n1", 1'b1);
        MODE = 4'b0001;
        clear_seq("rst.again");
        tick(); chk_out("rst.run0", 1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 2'd0);

        // asynchronous reset during init step 2, with no clock edge in between
        RESET = 1'b0;
        #2;
        RESET = 1'b1;
        tick(); cmd("ar.c1", 8'h38);
        tick(); cmd("ar.c2", 8'h0C);
        #2;
        RESET = 1'b0;
        #1;
        nop("ar.async", 1'b1);
        MODE = 4'b1010;
        @(negedge CLK);
        RESET = 1'b1;
        init_seq("ar.init");
        tick(); nop("ar.idle.a", 1'b0);
        tick(); nop("ar.idle.b", 1'b0);
        MODE = 4'b0100;
        clear_seq("ar.m2");
        tick(); chk_out("ar.run2", 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
